fetch_pc_stage: RTL and testbench
=================================

Name: fetch_pc_stage

Overview:
Fetch stage of the 5-stage pipeline. It holds the program counter and issues instruction-memory requests. It drives pc_plus4_o into input1 of the next-PC Mux32 and consumes that mux's output as next_pc_i. It also owns the IF/ID pipeline register, including stall, flush (redirect) and memory-wait handling.

Parameters:
RESET_PC, 32'h00000000, PC loaded on reset
NOP_INSTR, 32'h00000000, instruction word inserted as a bubble
CNT_W, 16, width of saturating stall counter

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  asynchronous active-low reset
next_pc_i  input  32  next PC from Mux32 output (PC+4 or branch target)
redirect_i  input  1  branch/jump taken in EX (same signal as Mux32 op)
stall_i  input  1  hazard-unit stall request
imem_rdata_i  input  32  instruction word from instruction memory
imem_ready_i  input  1  imem_rdata_i valid this cycle
imem_req_o  output  1  fetch request
imem_addr_o  output  32  fetch address (= pc_o)
pc_o  output  32  current PC
pc_plus4_o  output  32  pc_o + 4, to Mux32 input1
if_id_pc_o  output  32  PC of instruction in IF/ID
if_id_instr_o  output  32  instruction in IF/ID
if_id_valid_o  output  1  IF/ID holds a real instruction
stall_cnt_o  output  CNT_W  cycles lost to stall or memory wait

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, named rst_n.
- Reset values (asynchronous, while rst_n=0):
  - pc_o=RESET_PC, if_id_pc_o=0, if_id_instr_o=NOP_INSTR, if_id_valid_o=0
  - hold buffer cleared, stall_cnt_o=0, state=BOOT
- Combinational outputs:
  - pc_plus4_o = pc_o + 32'd4, wrapping modulo 2^32 (32'hFFFFFFFC -> 0)
  - imem_addr_o = pc_o
  - imem_req_o = 1 only in FETCH
- PC alignment: on every PC load, bits [1:0] are forced to 00.
- FSM states: BOOT, FETCH, HOLD.
- BOOT:
  - imem_req_o=0; unconditionally goes to FETCH on the next edge.
  - First request is issued in the cycle after reset release.
- Redirect, priority 1, any state except BOOT, on edge with redirect_i=1:
  - pc_o <= next_pc_i; IF/ID <= bubble (valid=0, NOP_INSTR, pc 0)
  - hold buffer discarded; state <= FETCH
  - Applies even if stall_i=1 or imem_ready_i=1 (wrong-path data dropped).
- FETCH, no redirect:
  - stall_i=0, imem_ready_i=1: IF/ID <= {pc_o, imem_rdata_i, valid=1}; pc_o <= next_pc_i. Single-cycle latency, request to IF/ID.
  - stall_i=0, imem_ready_i=0: pc_o holds; IF/ID <= bubble; counter increments.
  - stall_i=1, imem_ready_i=0: pc_o and IF/ID hold; counter increments.
  - stall_i=1, imem_ready_i=1: imem_rdata_i captured into hold buffer; pc_o and IF/ID hold; state <= HOLD; counter increments.
- HOLD (imem_req_o=0, no redirect):
  - stall_i=1: everything holds; counter increments.
  - stall_i=0: IF/ID <= {pc_o, buffer, valid=1}; pc_o <= next_pc_i; state <= FETCH.
- stall_cnt_o: saturates at all-ones and never wraps.
- Reset asserted mid-operation (any state, pending hold data): immediate return to reset values; hold data lost.

Decomposition:
- Shared package pipe_pkg:
  - fetch FSM state encoding (BOOT=2'd0, FETCH=2'd1, HOLD=2'd2)
  - NOP_INSTR constant
  - PC_STEP=32'd4
- Natural sub-module: if_id_reg, holding pc/instr/valid with load, hold and bubble controls.
- FSM, PC register, hold buffer and counter stay in fetch_pc_stage.
- Bench closes the loop by instantiating the existing Mux32: input1=pc_plus4_o, input2=branch target, op=redirect_i, out -> next_pc_i.

Test Plan:
- Reset/boot: rst_n low 3 cycles, release; imem_ready_i=1, rdata=32'h11111111 -> imem_req_o=0 for 1 cycle, then addr 0x0. Next edge: if_id_instr_o=32'h11111111, if_id_valid_o=1, pc_o=0x4.
- Sequential fetch: 4 cycles, ready=1, no redirect -> pc_o 0x4,0x8,0xC,0x10; if_id_pc_o trails by one, valid=1 throughout.
- Branch: redirect_i=1, target 32'h00000100 via Mux32 -> pc_o=0x100, if_id_valid_o=0, if_id_instr_o=0. Next cycle fetches 0x100.
- Stall with hold: stall_i=1 while ready=1, rdata=32'hDEADBEEF; 3 cycles -> pc_o constant, imem_req_o=0 in HOLD, stall_cnt_o+3. Stall drops: if_id_instr_o=32'hDEADBEEF, valid=1.
- Memory wait and alignment:
  - ready=0 for 2 cycles -> two bubbles, pc_o unchanged.
  - next_pc_i=32'h00000203 -> pc_o=32'h00000200.
  - PC 32'hFFFFFFFC -> pc_plus4_o=0.
- Reset mid-HOLD: assert rst_n=0 while in HOLD -> all outputs to reset values asynchronously, before the next edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: fetch FSM encoding, bubble instruction, PC step
// and the IF/ID payload layout.
package pipe_pkg;

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'd3;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Bubble wins over load; with neither it holds.
module if_id_reg
  import pipe_pkg::*;
#(
  parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        bubble_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic        valid_o
);

  if_id_t entry_q;
  if_id_t entry_d;

  always_comb begin
    entry_d = entry_q;
    if (bubble_i) begin
      entry_d = '{pc: 32'd0, instr: BUBBLE_INSTR, valid: 1'b0};
    end else if (load_i) begin
      entry_d = '{pc: pc_i, instr: instr_i, valid: 1'b1};
    end else begin
      entry_d = entry_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q <= '{pc: 32'd0, instr: BUBBLE_INSTR, valid: 1'b0};
    end else begin
      entry_q <= entry_d;
    end
  end

  assign pc_o    = entry_q.pc;
  assign instr_o = entry_q.instr;
  assign valid_o = entry_q.valid;

endmodule

// File: rtl/mux32.sv
// Two-way 32-bit next-PC selector: op=0 picks input1 (PC+4), op=1 picks input2.
module Mux32 (
  input  logic [31:0] input1,
  input  logic [31:0] input2,
  input  logic        op,
  output logic [31:0] out
);

  assign out = op ? input2 : input1;

endmodule

// File: rtl/fetch_pc_stage.sv
// Fetch stage: PC register, instruction-memory request FSM, stall/hold buffer
// and saturating lost-cycle counter, feeding the IF/ID register.
module fetch_pc_stage
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = pipe_pkg::NOP_INSTR,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      next_pc_i,
  input  logic             redirect_i,
  input  logic             stall_i,
  input  logic [31:0]      imem_rdata_i,
  input  logic             imem_ready_i,
  output logic             imem_req_o,
  output logic [31:0]      imem_addr_o,
  output logic [31:0]      pc_o,
  output logic [31:0]      pc_plus4_o,
  output logic [31:0]      if_id_pc_o,
  output logic [31:0]      if_id_instr_o,
  output logic             if_id_valid_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  logic [1:0]       state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_s, bubble_s;
  logic [31:0]      load_instr_s;
  logic [CNT_W-1:0] cnt_inc_s;

  assign cnt_inc_s = (cnt_q == {CNT_W{1'b1}}) ? cnt_q
                                              : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

  // Redirect overrides any in-flight data, including a buffered word in HOLD.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_d       = hold_q;
    cnt_d        = cnt_q;
    load_s       = 1'b0;
    bubble_s     = 1'b0;
    load_instr_s = imem_rdata_i;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (redirect_i) begin
          pc_d     = align_pc(next_pc_i);
          bubble_s = 1'b1;
          hold_d   = 32'd0;
        end else if (!stall_i && imem_ready_i) begin
          load_s = 1'b1;
          pc_d   = align_pc(next_pc_i);
        end else if (!stall_i) begin
          bubble_s = 1'b1;
          cnt_d    = cnt_inc_s;
        end else if (imem_ready_i) begin
          hold_d  = imem_rdata_i;
          state_d = ST_HOLD;
          cnt_d   = cnt_inc_s;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      ST_HOLD: begin
        if (redirect_i) begin
          pc_d     = align_pc(next_pc_i);
          bubble_s = 1'b1;
          hold_d   = 32'd0;
          state_d  = ST_FETCH;
        end else if (stall_i) begin
          cnt_d = cnt_inc_s;
        end else begin
          load_s       = 1'b1;
          load_instr_s = hold_q;
          pc_d         = align_pc(next_pc_i);
          state_d      = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= align_pc(RESET_PC);
      hold_q  <= 32'd0;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end

  if_id_reg #(.BUBBLE_INSTR(NOP_INSTR)) u_if_id (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (load_s),
    .bubble_i (bubble_s),
    .pc_i     (pc_q),
    .instr_i  (load_instr_s),
    .pc_o     (if_id_pc_o),
    .instr_o  (if_id_instr_o),
    .valid_o  (if_id_valid_o)
  );

  assign pc_o        = pc_q;
  assign imem_addr_o = pc_q;
  assign pc_plus4_o  = pc_q + PC_STEP;
  assign imem_req_o  = (state_q == ST_FETCH);
  assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Directed bench for fetch_pc_stage closed through Mux32, with a queued
// scoreboard checked on the falling edge; a CNT_W=2 copy exercises saturation.
module tb_fetch_pc_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect, stall, ready;
  logic [31:0] rdata, target, next_pc;

  logic        req, req2;
  logic [31:0] addr, pc, p4, ifpc, ifinstr;
  logic [31:0] addr2, pc2, p42, ifpc2, ifinstr2;
  logic        ifvalid, ifvalid2;
  logic [15:0] cnt;
  logic [1:0]  cnt2;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ifpc;
    logic [31:0] instr;
    logic        valid;
    logic        req;
    int          cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  Mux32 u_mux (.input1(p4), .input2(target), .op(redirect), .out(next_pc));

  fetch_pc_stage dut (
    .clk(clk), .rst_n(rst_n), .next_pc_i(next_pc), .redirect_i(redirect),
    .stall_i(stall), .imem_rdata_i(rdata), .imem_ready_i(ready),
    .imem_req_o(req), .imem_addr_o(addr), .pc_o(pc), .pc_plus4_o(p4),
    .if_id_pc_o(ifpc), .if_id_instr_o(ifinstr), .if_id_valid_o(ifvalid),
    .stall_cnt_o(cnt)
  );

  fetch_pc_stage #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .next_pc_i(next_pc), .redirect_i(redirect),
    .stall_i(stall), .imem_rdata_i(rdata), .imem_ready_i(ready),
    .imem_req_o(req2), .imem_addr_o(addr2), .pc_o(pc2), .pc_plus4_o(p42),
    .if_id_pc_o(ifpc2), .if_id_instr_o(ifinstr2), .if_id_valid_o(ifvalid2),
    .stall_cnt_o(cnt2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
    end
  endtask

  // Monitor: compare current outputs against the oldest queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [31:0] p4_exp;
      int          small_cnt;
      e         = exp_q.pop_front();
      p4_exp    = e.pc + 32'd4;
      small_cnt = (e.cnt > 3) ? 3 : e.cnt;
      chk("pc",        pc,          e.pc);
      chk("addr",      addr,        e.pc);
      chk("pc_plus4",  p4,          p4_exp);
      chk("req",       {31'd0, req},     {31'd0, e.req});
      chk("if_pc",     ifpc,        e.ifpc);
      chk("if_instr",  ifinstr,     e.instr);
      chk("if_valid",  {31'd0, ifvalid}, {31'd0, e.valid});
      chk("stall_cnt", {16'd0, cnt},     e.cnt);
      chk("sat_pc",    pc2,         e.pc);
      chk("sat_addr",  addr2,       e.pc);
      chk("sat_p4",    p42,         p4_exp);
      chk("sat_req",   {31'd0, req2},     {31'd0, e.req});
      chk("sat_if_pc", ifpc2,       e.ifpc);
      chk("sat_instr", ifinstr2,    e.instr);
      chk("sat_valid", {31'd0, ifvalid2}, {31'd0, e.valid});
      chk("sat_cnt",   {30'd0, cnt2},     small_cnt);
    end
  end

  // Queue the outputs expected before the coming edge, then advance one cycle.
  task automatic step(input logic [31:0] e_pc, input logic e_req, input logic [31:0] e_ifpc,
                      input logic [31:0] e_instr, input logic e_valid, input int e_cnt);
    exp_t e;
    e.pc = e_pc; e.req = e_req; e.ifpc = e_ifpc;
    e.instr = e_instr; e.valid = e_valid; e.cnt = e_cnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; redirect = 1'b0; stall = 1'b0; ready = 1'b1;
    rdata = 32'h1111_1111; target = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 0);                   // BOOT
    step(32'h0, 1'b1, 32'h0, 32'h0, 1'b0, 0);                   // first request
    rdata = 32'h2222_2222;
    step(32'h4, 1'b1, 32'h0, 32'h1111_1111, 1'b1, 0);
    rdata = 32'h3333_3333;
    step(32'h8, 1'b1, 32'h4, 32'h2222_2222, 1'b1, 0);
    rdata = 32'h4444_4444;
    step(32'hC, 1'b1, 32'h8, 32'h3333_3333, 1'b1, 0);
    redirect = 1'b1; target = 32'h100; rdata = 32'h5555_5555;   // branch, wrong-path dropped
    step(32'h10, 1'b1, 32'hC, 32'h4444_4444, 1'b1, 0);
    redirect = 1'b0; rdata = 32'h6666_6666;
    step(32'h100, 1'b1, 32'h0, 32'h0, 1'b0, 0);
    stall = 1'b1; rdata = 32'hDEAD_BEEF;                         // stall with data ready -> HOLD
    step(32'h104, 1'b1, 32'h100, 32'h6666_6666, 1'b1, 0);
    rdata = 32'h0BAD_F00D;
    step(32'h104, 1'b0, 32'h100, 32'h6666_6666, 1'b1, 1);
    step(32'h104, 1'b0, 32'h100, 32'h6666_6666, 1'b1, 2);
    stall = 1'b0;
    step(32'h104, 1'b0, 32'h100, 32'h6666_6666, 1'b1, 3);
    ready = 1'b0;                                                // memory wait
    step(32'h108, 1'b1, 32'h104, 32'hDEAD_BEEF, 1'b1, 3);
    step(32'h108, 1'b1, 32'h0, 32'h0, 1'b0, 4);
    ready = 1'b1; rdata = 32'h7777_7777;
    step(32'h108, 1'b1, 32'h0, 32'h0, 1'b0, 5);
    stall = 1'b1; ready = 1'b0;
    step(32'h10C, 1'b1, 32'h108, 32'h7777_7777, 1'b1, 5);
    stall = 1'b0; ready = 1'b1; redirect = 1'b1; target = 32'h203; // misaligned target
    step(32'h10C, 1'b1, 32'h108, 32'h7777_7777, 1'b1, 6);
    target = 32'hFFFF_FFFC;
    step(32'h200, 1'b1, 32'h0, 32'h0, 1'b0, 6);
    redirect = 1'b0; rdata = 32'h8888_8888;                      // PC+4 wraps to 0
    step(32'hFFFF_FFFC, 1'b1, 32'h0, 32'h0, 1'b0, 6);
    stall = 1'b1; rdata = 32'h9999_9999;
    step(32'h0, 1'b1, 32'hFFFF_FFFC, 32'h8888_8888, 1'b1, 6);
    redirect = 1'b1; target = 32'h300;                           // redirect beats stall in HOLD
    step(32'h0, 1'b0, 32'hFFFF_FFFC, 32'h8888_8888, 1'b1, 7);
    redirect = 1'b0; rdata = 32'hAAAA_AAAA;
    step(32'h300, 1'b1, 32'h0, 32'h0, 1'b0, 7);
    step(32'h300, 1'b0, 32'h0, 32'h0, 1'b0, 8);
    rst_n = 1'b0;                                                // async reset while in HOLD
    step(32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 0);
    rst_n = 1'b1; stall = 1'b0; rdata = 32'h1234_5678;
    step(32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 0);
    step(32'h0, 1'b1, 32'h0, 32'h0, 1'b0, 0);
    step(32'h4, 1'b1, 32'h0, 32'h1234_5678, 1'b1, 0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
